// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: D-stage register fields and branch resolve in, stall/flush/forward controls out.
// Pipeline side is master, scoreboard is slave; all controls are combinational in the same cycle.
interface hazard_scoreboard_if #(
   parameter int REG_ADDR_WIDTH = 5
);
   logic [REG_ADDR_WIDTH-1:0] Rs1D;
   logic [REG_ADDR_WIDTH-1:0] Rs2D;
   logic [REG_ADDR_WIDTH-1:0] RdD;
   logic                      RegWriteD;
   logic                      LoadD;
   logic                      MultiCycleD;
   logic                      PCSrcE;
   logic                      StallF;
   logic                      StallD;
   logic                      StallE;
   logic                      FlushD;
   logic                      FlushE;
   logic                      FlushM;
   logic [1:0]                ForwardAE;
   logic [1:0]                ForwardBE;

   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, LoadD, MultiCycleD, PCSrcE,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE
   );

   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, LoadD, MultiCycleD, PCSrcE,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// RV32I hazard/forwarding controller: shadow E/M/W register tracking, load-use and RAW stalls,
// branch flushes and a multi-cycle E-unit hold; all controls combinational, zero while in or just out of reset.
module hazard_scoreboard #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FWD_EN         = 1,
   parameter int MC_LATENCY     = 4,
   parameter int CNT_WIDTH      = 4
) (
   input logic               clk,
   input logic               rst,
   hazard_scoreboard_if.slave hz
);
   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rs1;
      logic [REG_ADDR_WIDTH-1:0] rs2;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      reg_write;
      logic                      load;
      logic                      multi_cycle;
   } stage_t;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      reg_write;
   } wb_t;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   stage_t               d_info, e_q;
   wb_t                  m_q, w_q;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 init_q;
   logic                 mc_stall, raw_e, raw_m, load_use, hazard;
   logic                 stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
   logic [1:0]           fwd_a, fwd_b;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs, input wb_t m, input wb_t w);
      if (m.reg_write && m.rd != '0 && m.rd == rs) return 2'b10;
      else if (w.reg_write && w.rd != '0 && w.rd == rs) return 2'b01;
      else return 2'b00;
   endfunction

   assign d_info = '{rs1: hz.Rs1D, rs2: hz.Rs2D, rd: hz.RdD, reg_write: hz.RegWriteD,
                     load: hz.LoadD, multi_cycle: hz.MultiCycleD};

   // Masks every control for the partial cycle after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) init_q <= 1'b1;
      else     init_q <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         if (!stall_e) e_q <= flush_e ? '0 : d_info;
         m_q <= flush_m ? '0 : '{rd: e_q.rd, reg_write: e_q.reg_write};
         w_q <= m_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (e_q.multi_cycle) begin
            state_d = BUSY;
            cnt_d   = CNT_WIDTH'(MC_LATENCY - 1);
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_WIDTH'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The op's first E cycle is held from IDLE; the counter==1 cycle releases it so E lasts MC_LATENCY cycles.
   assign mc_stall = (state_q == IDLE && e_q.multi_cycle) || (state_q == BUSY && cnt_q != CNT_WIDTH'(1));

   assign raw_e    = e_q.reg_write && e_q.rd != '0 && (e_q.rd == hz.Rs1D || e_q.rd == hz.Rs2D);
   assign raw_m    = m_q.reg_write && m_q.rd != '0 && (m_q.rd == hz.Rs1D || m_q.rd == hz.Rs2D);
   assign load_use = e_q.load && e_q.rd != '0 && (e_q.rd == hz.Rs1D || e_q.rd == hz.Rs2D);
   assign hazard   = (FWD_EN != 0) ? load_use : (raw_e || raw_m);

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
      if (!init_q) begin
         if (FWD_EN != 0) begin
            fwd_a = fwd_sel(e_q.rs1, m_q, w_q);
            fwd_b = fwd_sel(e_q.rs2, m_q, w_q);
         end
         if (mc_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushM    = flush_m;
   assign hz.ForwardAE = fwd_a;
   assign hz.ForwardBE = fwd_b;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding and a non-forwarding instance run the same short programs
// against an instruction-level pipeline model, plus hand-computed control vectors per scenario.
module tb_hazard_scoreboard;
   localparam int AW = 5;
   localparam int MC = 4;
   // Vector layout: {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE}
   localparam logic [9:0] ZERO     = 10'b0000000000;
   localparam logic [9:0] LU_STALL = 10'b1100100000;
   localparam logic [9:0] MC_STALL = 10'b1110010000;
   localparam logic [9:0] BR_FLUSH = 10'b0001100000;
   localparam logic [9:0] FWD_A_M  = 10'b0000001000;
   localparam logic [9:0] FWD_AB_W = 10'b0000000101;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_ADDR_WIDTH(AW)) hif0 ();
   hazard_scoreboard_if #(.REG_ADDR_WIDTH(AW)) hif1 ();

   hazard_scoreboard #(.REG_ADDR_WIDTH(AW), .FWD_EN(0), .MC_LATENCY(MC), .CNT_WIDTH(4))
      dut0 (.clk(clk), .rst(rst), .hz(hif0));
   hazard_scoreboard #(.REG_ADDR_WIDTH(AW), .FWD_EN(1), .MC_LATENCY(MC), .CNT_WIDTH(4))
      dut1 (.clk(clk), .rst(rst), .hz(hif1));

   logic [9:0] act0, act1;
   assign act0 = {hif0.StallF, hif0.StallD, hif0.StallE, hif0.FlushD, hif0.FlushE, hif0.FlushM,
                  hif0.ForwardAE, hif0.ForwardBE};
   assign act1 = {hif1.StallF, hif1.StallD, hif1.StallE, hif1.FlushD, hif1.FlushE, hif1.FlushM,
                  hif1.ForwardAE, hif1.ForwardBE};

   typedef struct packed {
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
      logic          we;
      logic          ld;
      logic          mc;
      logic          br;
   } ins_t;

   typedef struct {
      ins_t d;
      ins_t e;
      ins_t m;
      ins_t w;
      int   e_age;
      int   pc;
   } mdl_t;

   typedef struct {
      int         cyc;
      int         dut;
      logic [9:0] val;
   } pin_t;

   ins_t       prog[$];
   pin_t       pins[$];
   mdl_t       mdl[2];
   logic [9:0] exp_v[2];
   bit         fresh;
   int         cyc;
   int         n_tests = 0;
   int         n_fail  = 0;
   string      sc_name;

   function automatic ins_t mk(input int rs1, input int rs2, input int rd,
                               input bit we, input bit ld, input bit mc, input bit br);
      ins_t i;
      i.rs1 = AW'(rs1);
      i.rs2 = AW'(rs2);
      i.rd  = AW'(rd);
      i.we  = we;
      i.ld  = ld;
      i.mc  = mc;
      i.br  = br;
      return i;
   endfunction

   function automatic mdl_t blank();
      mdl_t s;
      s.d = '0;
      s.e = '0;
      s.m = '0;
      s.w = '0;
      s.e_age = 1;
      s.pc = 0;
      return s;
   endfunction

   function automatic logic [1:0] fsel(input ins_t m, input ins_t w, input logic [AW-1:0] r);
      if (m.we && m.rd != 0 && m.rd == r) return 2'b10;
      if (w.we && w.rd != 0 && w.rd == r) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit reads(input ins_t p, input ins_t d);
      return p.we && p.rd != 0 && (p.rd == d.rs1 || p.rd == d.rs2);
   endfunction

   // Controls implied by what sits in D/E/M/W and how long the E op has been there.
   function automatic logic [9:0] exp_out(input mdl_t s, input bit fwd);
      logic [9:0] o;
      bit hz;
      o = '0;
      if (fwd) begin
         o[3:2] = fsel(s.m, s.w, s.e.rs1);
         o[1:0] = fsel(s.m, s.w, s.e.rs2);
         hz = s.e.ld && s.e.rd != 0 && (s.e.rd == s.d.rs1 || s.e.rd == s.d.rs2);
      end else begin
         hz = reads(s.e, s.d) || reads(s.m, s.d);
      end
      if (s.e.mc && s.e_age < MC) o[9:4] = 6'b111001;
      else if (s.e.br)            o[9:4] = 6'b000110;
      else if (hz)                o[9:4] = 6'b110010;
      return o;
   endfunction

   function automatic mdl_t step(input mdl_t s, input logic [9:0] o);
      mdl_t n;
      n = s;
      n.w = s.m;
      n.m = o[4] ? '0 : s.e;
      if (o[7]) n.e_age = s.e_age + 1;
      else begin
         n.e = o[5] ? '0 : s.d;
         n.e_age = 1;
      end
      if (!o[8]) begin
         if (o[6]) n.d = '0;
         else begin
            n.d = (s.pc < prog.size()) ? prog[s.pc] : '0;
            n.pc = s.pc + 1;
         end
      end
      return n;
   endfunction

   function automatic void pin(input int c, input int d, input logic [9:0] v);
      pins.push_back('{c, d, v});
   endfunction

   task automatic check(input string nm, input logic [9:0] got, input logic [9:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, want);
      end
   endtask

   task automatic drive();
      hif0.Rs1D = mdl[0].d.rs1;  hif0.Rs2D = mdl[0].d.rs2;  hif0.RdD = mdl[0].d.rd;
      hif0.RegWriteD = mdl[0].d.we;  hif0.LoadD = mdl[0].d.ld;  hif0.MultiCycleD = mdl[0].d.mc;
      hif0.PCSrcE = mdl[0].e.br;
      hif1.Rs1D = mdl[1].d.rs1;  hif1.Rs2D = mdl[1].d.rs2;  hif1.RdD = mdl[1].d.rd;
      hif1.RegWriteD = mdl[1].d.we;  hif1.LoadD = mdl[1].d.ld;  hif1.MultiCycleD = mdl[1].d.mc;
      hif1.PCSrcE = mdl[1].e.br;
   endtask

   task automatic tick(input bit rel);
      logic [9:0] a;
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 2; k++) mdl[k] = step(mdl[k], exp_v[k]);
         fresh = 1'b0;
      end
      #1;
      drive();
      if (rel) rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_v[k] = (rst || fresh) ? ZERO : exp_out(mdl[k], k == 1);
         a = (k == 0) ? act0 : act1;
         check($sformatf("%s dut%0d", sc_name, k), a, exp_v[k]);
         foreach (pins[i])
            if (pins[i].cyc == cyc && pins[i].dut == k)
               check($sformatf("%s pin dut%0d", sc_name, k), a, pins[i].val);
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fresh = 1'b1;
      for (int k = 0; k < 2; k++) mdl[k] = blank();
      cyc = -3;
      for (int i = 0; i < 3; i++) tick(1'b0);
      tick(1'b1);
   endtask

   task automatic run(input string nm, input int n);
      sc_name = nm;
      do_reset();
      for (int i = 0; i < n; i++) tick(1'b0);
      pins.delete();
   endtask

   task automatic load_mul_prog();
      prog.delete();
      prog.push_back(mk(1, 2, 7, 1, 0, 1, 0));   // mul x7,x1,x2
      prog.push_back(mk(7, 3, 8, 1, 0, 0, 0));   // add x8,x7,x3
      pin(2, 1, MC_STALL); pin(3, 1, MC_STALL); pin(4, 1, MC_STALL);
      pin(5, 1, ZERO);     pin(6, 1, FWD_A_M);
      pin(2, 0, MC_STALL); pin(3, 0, MC_STALL); pin(4, 0, MC_STALL);
      pin(5, 0, LU_STALL); pin(6, 0, LU_STALL); pin(7, 0, ZERO);
   endtask

   initial begin
      rst = 1'b1;
      fresh = 1'b1;
      for (int k = 0; k < 2; k++) begin
         mdl[k] = blank();
         exp_v[k] = ZERO;
      end
      drive();

      prog.delete();
      prog.push_back(mk(1, 2, 5, 1, 0, 0, 0));   // add x5,x1,x2
      prog.push_back(mk(5, 3, 6, 1, 0, 0, 0));   // sub x6,x5,x3
      pin(2, 1, ZERO); pin(3, 1, FWD_A_M);
      pin(2, 0, LU_STALL); pin(3, 0, LU_STALL); pin(4, 0, ZERO);
      run("raw_alu", 8);

      prog.delete();
      prog.push_back(mk(0, 0, 5, 1, 1, 0, 0));   // lw x5,0(x0)
      prog.push_back(mk(5, 5, 6, 1, 0, 0, 0));   // add x6,x5,x5
      pin(2, 1, LU_STALL); pin(3, 1, ZERO); pin(4, 1, FWD_AB_W);
      pin(2, 0, LU_STALL); pin(3, 0, LU_STALL); pin(4, 0, ZERO);
      run("load_use", 8);

      prog.delete();
      prog.push_back(mk(0, 0, 5, 1, 1, 0, 0));   // lw x5,0(x0)
      prog.push_back(mk(1, 2, 0, 0, 0, 0, 1));   // beq x1,x2 (taken)
      prog.push_back(mk(5, 0, 6, 1, 0, 0, 0));   // wrong path, dependent on the load
      prog.push_back(mk(5, 0, 7, 1, 0, 0, 0));   // branch target
      for (int k = 0; k < 2; k++) begin
         pin(2, k, ZERO); pin(3, k, BR_FLUSH); pin(4, k, ZERO);
      end
      run("branch", 8);

      load_mul_prog();
      run("multi_cycle", 10);

      prog.delete();
      prog.push_back(mk(1, 0, 0, 1, 0, 0, 0));   // addi x0,x1
      prog.push_back(mk(0, 0, 6, 1, 0, 0, 0));   // add x6,x0,x0
      prog.push_back(mk(1, 0, 0, 1, 1, 0, 0));   // lw x0,0(x1)
      prog.push_back(mk(0, 0, 9, 1, 0, 0, 0));   // add x9,x0,x0
      for (int c = 1; c <= 6; c++) begin
         pin(c, 0, ZERO); pin(c, 1, ZERO);
      end
      run("x0", 8);

      prog.delete();
      prog.push_back(mk(1, 2, 7, 1, 0, 1, 0));
      pin(2, 0, MC_STALL); pin(2, 1, MC_STALL);
      sc_name = "mid_busy";
      do_reset();
      tick(1'b0);
      tick(1'b0);
      pins.delete();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_busy_rst dut0", act0, ZERO);
      check("mid_busy_rst dut1", act1, ZERO);

      load_mul_prog();
      run("mc_after_rst", 10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Tracks the destination/source registers of in-flight instructions in E, M and W using its own shadow pipeline.
- Generates per-stage stall and flush enables plus ALU operand forwarding selects.
- Supports load-use stalls, taken-branch/jump flushes, a parametrised multi-cycle execute unit, and a no-forwarding mode (stall until the value is safe).

Parameters:
- REG_ADDR_WIDTH, 5, width of rs1/rs2/rd fields.
- FWD_EN, 1, 1 = forward from M/W to E; 0 = no forwarding, resolve RAW hazards by stalling in D.
- MC_LATENCY, 4, cycles a multi-cycle E-stage op (mul/div) occupies E; legal range 2..15.
- CNT_WIDTH, 4, width of multi-cycle counter; must hold MC_LATENCY-1.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-high reset
- Rs1D  input  REG_ADDR_WIDTH  rs1 of instruction in D
- Rs2D  input  REG_ADDR_WIDTH  rs2 of instruction in D
- RdD  input  REG_ADDR_WIDTH  rd of instruction in D
- RegWriteD  input  1  D instruction writes rd
- LoadD  input  1  D instruction is a load (ResultSrc = memory)
- MultiCycleD  input  1  D instruction is a multi-cycle E op
- PCSrcE  input  1  branch taken / jump resolved in E this cycle
- StallF  output  1  hold PC
- StallD  output  1  hold F/D register
- StallE  output  1  hold D/E register
- FlushD  output  1  clear F/D register (insert NOP)
- FlushE  output  1  clear D/E register (bubble)
- FlushM  output  1  clear E/M register (bubble)
- ForwardAE  output  2  ALU op1 select: 00 RD1E, 01 W result, 10 ALUResultM
- ForwardBE  output  2  ALU op2 select, same encoding

Behaviour:
- Reset: shadow stages cleared (RegWrite=0, Load=0, Rd=0), counter=0, state IDLE. All outputs 0 while rst is high and in the cycle after release.
- Shadow pipeline (posedge clk):
  - E <= hold if StallE; else bubble if FlushE; else {Rs1D,Rs2D,RdD,RegWriteD,LoadD}.
  - M <= bubble if FlushM; else E.
  - W <= M.
- Register x0 never creates a hazard: any rd=0 match is ignored.
- Forwarding (combinational, FWD_EN=1):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00. M has priority over W. ForwardBE is the same with Rs2E.
- FWD_EN=0: forward selects are tied to 00. RAW stall in D while a matching rd with RegWrite=1 exists in E or M. The register file writes in the first half-cycle, so a W match never stalls.
- Load-use stall (FWD_EN=1): LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) asserts StallF, StallD and FlushE for exactly 1 cycle.
- Multi-cycle FSM, states IDLE and BUSY:
  - IDLE->BUSY when the E instruction has MultiCycle set; counter loads MC_LATENCY-1.
  - In BUSY: StallF, StallD and StallE are asserted, FlushM=1, and the counter decrements each cycle.
  - BUSY->IDLE when counter==1. The op leaves E on the following edge, giving MC_LATENCY total cycles in E.
  - The MultiCycle flag is held in the E shadow so it survives StallE.
- Branch flush: PCSrcE asserts FlushD and FlushE in the same cycle.
- Priority:
  - PCSrcE overrides load-use and RAW stalls: flush, no stall.
  - BUSY overrides everything; PCSrcE cannot occur while BUSY because the E op is the multi-cycle op.
- Simultaneous load-use and RAW (FWD_EN=0): a single stall; both conditions are re-evaluated each cycle.
- Reset asserted mid-BUSY: the FSM returns to IDLE asynchronously, and all stalls and flushes drop immediately.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 (FWD_EN=1) -> ForwardAE=10 in the sub's E cycle; no stall; x6 correct.
- lw x5,0(x0) then add x6,x5,x5 -> one cycle of StallF=StallD=FlushE=1, then ForwardAE=ForwardBE=01; exactly 1 bubble.
- beq taken in E with load-use pending in D -> FlushD=FlushE=1, StallF=StallD=0, PC takes the branch target next cycle.
- mul x7,x1,x2 with MC_LATENCY=4 -> StallE=FlushM=1 for 3 cycles; the mul occupies E for 4 cycles; the dependent add gets ForwardAE=10.
- FWD_EN=0: add x5 then add x6,x5,x0 -> StallD=1 for 2 cycles; ForwardAE stays 00; correct result.
- Writes to x0 followed by reads of x0 -> no forwarding and no stall; asserting rst mid-BUSY -> all outputs 0 within the same cycle.
